prog_sequencer: RTL
===================

# prog_sequencer

Parametrised program sequencer for the next-generation processor top level. It owns the program counter, the Start/Ack run handshake, and the cycle and instruction counters that the single-cycle top level handled inline. It adds selectable program entry points, absolute and signed-relative branches, memory stall support, saturating counters and an optional watchdog. It drives the instruction ROM address and gates architectural writes through `Run`.

## Interface
- `PC_W`, 10, program counter width; ROM depth 2^PC_W.
- `NPROG`, 4, number of selectable program entry points (≥1).
- `CNT_W`, 16, width of `CycleCt` / `InstCt`.
- `WDOG_LIMIT`, 16'hFFF0, watchdog cycle limit; only used with `SEQ_WATCHDOG_EN`.

Ports:
- `Clk` in 1: clock, posedge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: level; starts or restarts a program.
- `ProgSel` in max(1,$clog2(NPROG)): entry-point index, sampled with `Start`.
- `EntryAddr` in NPROG*PC_W: flattened entry table; entry i at [i*PC_W +: PC_W].
- `Halt` in 1: decoder flags the current instruction as the done opcode.
- `BranchAbs` in 1: unconditional jump to `Target`.
- `BranchRelEn` in 1: conditional relative branch, taken when `Cond`=1.
- `Cond` in 1: ALU zero/condition flag.
- `Target` in PC_W: absolute address, or signed two's-complement offset for relative branches.
- `Stall` in 1: data memory not ready; freezes the current instruction.
- `ProgCtr` out PC_W: instruction ROM address.
- `Run` out 1: 1 when the current instruction may commit (state RUN and `Stall`=0).
- `Ack` out 1: program done.
- `Timeout` out 1: watchdog expiry.
- `CycleCt` out CNT_W: cycles spent in RUN.
- `InstCt` out CNT_W: instructions retired.

## Operation
- States: IDLE, RUN, DONE. Priority is `Start` > `Stall` > `Halt` > `BranchAbs` > `BranchRelEn&&Cond` > sequential.
- **`Start`=1 in any state:**
  - `ProgCtr` ← entry[`ProgSel`]; counters ← 0; `Ack`, `Timeout` ← 0.
  - Next state is RUN, but the sequencer stays in this load behaviour while `Start` is held.
  - A `ProgSel` ≥ NPROG selects entry 0.
- **IDLE:** everything holds; `Run`=0.
- **RUN, `Stall`=1:** `ProgCtr` and `InstCt` hold; `CycleCt` increments.
- **RUN, `Halt`:**
  - Next state DONE; `ProgCtr` holds; `Ack` ← 1.
  - The halt instruction is not counted in `InstCt`.
- **RUN, `BranchAbs`:** `ProgCtr` ← `Target`.
- **RUN, relative branch taken:** `ProgCtr` ← `ProgCtr` + sign-extended `Target`, modulo 2^PC_W.
- **RUN, otherwise:** `ProgCtr` ← `ProgCtr`+1; wraps from 2^PC_W−1 to 0 with no flag.
- **RUN, every non-stalled non-halt cycle:** `InstCt` increments.
- **Counters:** saturate at all-ones; they never wrap.
- **DONE:** everything holds; `Ack`=1; `Run`=0. Only `Start` leaves DONE.

## Timing
- **Reset asserted:**
  - State IDLE; `ProgCtr`=0; `Ack`=0, `Timeout`=0, `Run`=0; counters 0.
  - Takes effect immediately, including mid-RUN or mid-stall. The program is lost and no `Ack` is produced.
- **Release:** synchronous to `Clk`. The first edge after release samples inputs normally.
- **`ProgCtr`, `Ack`, `Timeout` and counters:** registered, updating one edge after the deciding inputs.
- **`Run`:** combinational from state and `Stall`.
- **Start latency:** with `Start` high at edge N and low at edge N+1, the first instruction (entry address) is presented after edge N. It commits at edge N+1 if `Stall`=0.
- **Halt latency:** with `Halt` sampled at edge M, `Ack` is high after edge M and stays high until `Start` or `Reset`.
- **Simultaneous inputs:**
  - `Halt` with `Stall`: stall wins, and the halt is re-evaluated the next cycle.
  - `Halt` with a branch: halt wins.

## Configuration
- `SEQ_WATCHDOG_EN` defined:
  - In RUN, once `CycleCt` equals `WDOG_LIMIT`, the next edge goes to DONE with `Ack`=1 and `Timeout`=1.
  - A coincident `Halt` takes priority, giving `Timeout`=0.
- `SEQ_WATCHDOG_EN` undefined: `Timeout` is tied to 0, `WDOG_LIMIT` is ignored, and there is no watchdog logic.

## Test plan
- **Reset and start:** `Reset`=0 then released; `EntryAddr` entry 2=10'h040; `ProgSel`=2; `Start` pulsed for 1 cycle.
  - Required: `ProgCtr`=0x040, then 0x041, 0x042…; `Run`=1; `InstCt` tracks retired instructions.
- **Branches:**
  - At PC 0x045, `BranchRelEn`=1, `Cond`=1, `Target`=10'h3FC (−4) → next PC 0x041.
  - Same inputs with `Cond`=0 → 0x046.
  - `BranchAbs` with `Target`=0x3FF, followed by one sequential cycle → 0x000 (wrap).
- **Stall:** `Stall` held high for 3 cycles at PC 0x050.
  - Required: PC stays at 0x050, `CycleCt` +3, `InstCt` +0, `Run`=0.
  - A `Halt` asserted during the stall is ignored until the stall drops.
- **Halt:** `Halt` asserted at PC 0x060 after 5 retired instructions.
  - Required: `Ack`=1 the next cycle; `InstCt`=5; PC holds at 0x060.
  - `Start` re-asserted → `Ack` drops and the PC reloads the entry address.
- **Asynchronous reset mid-run:** `Reset` dropped asynchronously mid-RUN.
  - Required: all outputs 0 immediately, with no clock edge needed.
- **Watchdog:** with `SEQ_WATCHDOG_EN`, `WDOG_LIMIT`=20, a program looping forever.
  - Required: `Ack`=1 and `Timeout`=1 after 21 RUN cycles.
  - Without the macro: the program keeps running, and `CycleCt` saturates at 0xFFFF with `CNT_W`=16.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, Start/Ack handshake, saturating cycle/instruction counters.
// Optional watchdog enabled by defining SEQ_WATCHDOG_EN.
module prog_sequencer #(
  parameter int              PC_W       = 10,
  parameter int              NPROG      = 4,
  parameter int              CNT_W      = 16,
  parameter logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'('hFFF0)
) (
  input  logic                                       Clk,
  input  logic                                       Reset,
  input  logic                                       Start,
  input  logic [((NPROG > 1) ? $clog2(NPROG) : 1)-1:0] ProgSel,
  input  logic [NPROG*PC_W-1:0]                      EntryAddr,
  input  logic                                       Halt,
  input  logic                                       BranchAbs,
  input  logic                                       BranchRelEn,
  input  logic                                       Cond,
  input  logic [PC_W-1:0]                            Target,
  input  logic                                       Stall,
  output logic [PC_W-1:0]                            ProgCtr,
  output logic                                       Run,
  output logic                                       Ack,
  output logic                                       Timeout,
  output logic [CNT_W-1:0]                           CycleCt,
  output logic [CNT_W-1:0]                           InstCt
);

  localparam int SEL_W = (NPROG > 1) ? $clog2(NPROG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [PC_W-1:0] entry_pc;
  logic [PC_W-1:0] next_pc;

  if (NPROG < 1 || WDOG_LIMIT == '0) begin : g_bad_cfg
    $error("prog_sequencer: NPROG must be >= 1 and WDOG_LIMIT nonzero");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Out-of-range selects never match a loop index, so they fall back to entry 0.
  always_comb begin
    entry_pc = EntryAddr[PC_W-1:0];
    for (int i = 1; i < NPROG; i++) begin
      if (ProgSel == SEL_W'(i)) entry_pc = EntryAddr[i*PC_W +: PC_W];
    end
  end

  // A PC_W-bit add of the raw offset is the sign-extended add modulo 2^PC_W.
  always_comb begin
    next_pc = ProgCtr + 1'b1;
    if (BranchAbs)              next_pc = Target;
    else if (BranchRelEn && Cond) next_pc = ProgCtr + Target;
  end

  assign Run = (state == RUN) && !Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      ProgCtr <= '0;
      Ack     <= 1'b0;
      CycleCt <= '0;
      InstCt  <= '0;
`ifdef SEQ_WATCHDOG_EN
      Timeout <= 1'b0;
`endif
    end else if (Start) begin
      state   <= RUN;
      ProgCtr <= entry_pc;
      Ack     <= 1'b0;
      CycleCt <= '0;
      InstCt  <= '0;
`ifdef SEQ_WATCHDOG_EN
      Timeout <= 1'b0;
`endif
    end else if (state == RUN) begin
      CycleCt <= sat_inc(CycleCt);
      // A halt under stall is not taken; it is seen again once the stall drops.
      if (!Stall && Halt) begin
        state <= DONE;
        Ack   <= 1'b1;
      end
`ifdef SEQ_WATCHDOG_EN
      else if (CycleCt == WDOG_LIMIT) begin
        state   <= DONE;
        Ack     <= 1'b1;
        Timeout <= 1'b1;
      end
`endif
      else if (!Stall) begin
        ProgCtr <= next_pc;
        InstCt  <= sat_inc(InstCt);
      end
    end
  end

`ifndef SEQ_WATCHDOG_EN
  assign Timeout = 1'b0;
`endif

endmodule
